// File: rtl/mult_result_accumulator_if.sv
// mult_result_accumulator_if
//   Bundles the product input, group-sum output handshake and status
//   lines of the multiplier result accumulator.
//
//   Ports (signals carried by the interface):
//     done_i       product-valid pulse from the multiplier
//     prod_i       product value, meaningful only while done_i=1
//     clear_i      synchronous abort of the group in progress
//     sum_o        completed group sum (held while sum_valid_o=1)
//     ovf_o        saturation flag belonging to sum_o
//     sum_valid_o  sum_o/ovf_o valid
//     sum_ready_i  sink accepts sum_o
//     busy_o       group partially accumulated or sum held
//     drop_o       one-cycle pulse: a product was discarded
//
//   Modports: master = product source / sum sink side,
//             slave  = the accumulator itself.
interface mult_result_accumulator_if #(
  parameter int PROD_W = 8,
  parameter int ACC_W  = 10
);
  logic              done_i;
  logic [PROD_W-1:0] prod_i;
  logic              clear_i;
  logic [ACC_W-1:0]  sum_o;
  logic              ovf_o;
  logic              sum_valid_o;
  logic              sum_ready_i;
  logic              busy_o;
  logic              drop_o;

  modport master (
    output done_i, prod_i, clear_i, sum_ready_i,
    input  sum_o, ovf_o, sum_valid_o, busy_o, drop_o
  );

  modport slave (
    input  done_i, prod_i, clear_i, sum_ready_i,
    output sum_o, ovf_o, sum_valid_o, busy_o, drop_o
  );
endinterface

// File: rtl/mult_result_accumulator.sv
// mult_result_accumulator
//   Sums groups of NUM_TERMS consecutive multiplier products and presents
//   each group sum through a valid/ready output register. The next group
//   keeps accumulating while a finished sum waits for the sink; only the
//   final product of a group that completes during a stall is discarded.
//
//   Ports:
//     clk_in  sole clock, rising edge
//     rst_in  asynchronous active-low reset
//     bus     mult_result_accumulator_if.slave (product in, sum out,
//             busy/drop status)
module mult_result_accumulator #(
  parameter int PROD_W    = 8,
  parameter int NUM_TERMS = 4,
  parameter int ACC_W     = 10
) (
  input logic                        clk_in,
  input logic                        rst_in,
  mult_result_accumulator_if.slave   bus
);

  localparam int CNT_W = (NUM_TERMS > 1) ? $clog2(NUM_TERMS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_TERMS - 1);

  // Accumulation state for the group in progress
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             acc_ovf_q, acc_ovf_d;

  // Output register and the drop pulse
  logic [ACC_W-1:0] sum_q, sum_d;
  logic             ovf_q, ovf_d;
  logic             valid_q, valid_d;
  logic             drop_q, drop_d;

  // Saturating add of the incoming product
  logic [ACC_W:0]   sum_ext;
  logic [ACC_W-1:0] add_acc;
  logic             add_ovf;
  logic             out_free;

  // One extra bit catches the carry; once a group has saturated it stays
  // pinned at all-ones regardless of later products.
  always_comb begin
    sum_ext  = {1'b0, acc_q} + (ACC_W + 1)'(bus.prod_i);
    add_ovf  = acc_ovf_q | sum_ext[ACC_W];
    add_acc  = add_ovf ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
    out_free = ~valid_q | bus.sum_ready_i;
  end

  // Next-state logic. The held sum drops out on a transfer unless a new
  // group completes in the same cycle, in which case it is replaced.
  // clear_i only touches the accumulation state, never the output side.
  always_comb begin
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    acc_ovf_d = acc_ovf_q;
    sum_d     = sum_q;
    ovf_d     = ovf_q;
    valid_d   = valid_q & ~bus.sum_ready_i;
    drop_d    = 1'b0;

    if (bus.clear_i) begin
      acc_d     = '0;
      cnt_d     = '0;
      acc_ovf_d = 1'b0;
    end else if (bus.done_i) begin
      if (cnt_q != LAST_CNT) begin
        acc_d     = add_acc;
        cnt_d     = cnt_q + CNT_W'(1);
        acc_ovf_d = add_ovf;
      end else if (out_free) begin
        sum_d     = add_acc;
        ovf_d     = add_ovf;
        valid_d   = 1'b1;
        acc_d     = '0;
        cnt_d     = '0;
        acc_ovf_d = 1'b0;
      end else begin
        // Output still stalled: discard the product and leave the group
        // waiting for its final term to arrive again.
        drop_d = 1'b1;
      end
    end
  end

  // State and output registers
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      acc_q     <= '0;
      cnt_q     <= '0;
      acc_ovf_q <= 1'b0;
      sum_q     <= '0;
      ovf_q     <= 1'b0;
      valid_q   <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      acc_ovf_q <= acc_ovf_d;
      sum_q     <= sum_d;
      ovf_q     <= ovf_d;
      valid_q   <= valid_d;
      drop_q    <= drop_d;
    end
  end

  assign bus.sum_o       = sum_q;
  assign bus.ovf_o       = ovf_q;
  assign bus.sum_valid_o = valid_q;
  assign bus.drop_o      = drop_q;
  assign bus.busy_o      = (cnt_q != '0) | (acc_q != '0) | valid_q;

endmodule

// File: tb/tb_mult_result_accumulator.sv
// tb_mult_result_accumulator
//   Directed bench for mult_result_accumulator with a 9-bit accumulator so
//   that four 225 products saturate. Expected group results are queued
//   when the final product of a group is driven and compared when the
//   output register loads.
module tb_mult_result_accumulator;

  localparam int PROD_W    = 8;
  localparam int NUM_TERMS = 4;
  localparam int ACC_W     = 9;

  typedef struct packed {
    logic [ACC_W-1:0] sum;
    logic             ovf;
  } exp_t;

  logic clk_in;
  logic rst_in;
  int   checks;
  int   errors;
  exp_t sb[$];

  mult_result_accumulator_if #(.PROD_W(PROD_W), .ACC_W(ACC_W)) bus ();

  mult_result_accumulator #(
    .PROD_W   (PROD_W),
    .NUM_TERMS(NUM_TERMS),
    .ACC_W    (ACC_W)
  ) dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .bus   (bus.slave)
  );

  // Free-running 10 ns clock
  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Drive one cycle of inputs, then sample 1 ns after the edge
  task automatic apply_stimulus(input logic done, input logic [PROD_W-1:0] prod,
                                input logic clear, input logic ready);
    bus.done_i      = done;
    bus.prod_i      = prod;
    bus.clear_i     = clear;
    bus.sum_ready_i = ready;
    @(posedge clk_in);
    #1;
  endtask

  // Compare the freshly loaded output register against the queued result
  task automatic check_output(input string tag);
    exp_t e;
    checks++;
    assert (sb.size() != 0)
    else begin
      errors++;
      $error("[TB] FAIL %s_pending observed=0 expected=1 entries", tag);
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check({tag, "_valid"}, 32'(bus.sum_valid_o), 32'd1);
      check({tag, "_sum"}, 32'(bus.sum_o), 32'(e.sum));
      check({tag, "_ovf"}, 32'(bus.ovf_o), 32'(e.ovf));
    end
  endtask

  function automatic exp_t mk(input int s, input logic o);
    exp_t e;
    e.sum = ACC_W'(s);
    e.ovf = o;
    return e;
  endfunction

  initial begin
    checks          = 0;
    errors          = 0;
    rst_in          = 1'b0;
    bus.done_i      = 1'b0;
    bus.prod_i      = '0;
    bus.clear_i     = 1'b0;
    bus.sum_ready_i = 1'b0;

    // Reset state
    apply_stimulus(1'b0, 8'd0, 1'b0, 1'b0);
    apply_stimulus(1'b0, 8'd0, 1'b0, 1'b0);
    check("rst_sum", 32'(bus.sum_o), 32'd0);
    check("rst_valid", 32'(bus.sum_valid_o), 32'd0);
    check("rst_ovf", 32'(bus.ovf_o), 32'd0);
    check("rst_busy", 32'(bus.busy_o), 32'd0);
    check("rst_drop", 32'(bus.drop_o), 32'd0);
    rst_in = 1'b1;
    apply_stimulus(1'b0, 8'd0, 1'b0, 1'b0);

    // Basic group 3+5+7+9
    apply_stimulus(1'b1, 8'd3, 1'b0, 1'b1);
    check("basic_busy", 32'(bus.busy_o), 32'd1);
    apply_stimulus(1'b1, 8'd5, 1'b0, 1'b1);
    apply_stimulus(1'b1, 8'd7, 1'b0, 1'b1);
    check("basic_early_valid", 32'(bus.sum_valid_o), 32'd0);
    sb.push_back(mk(24, 1'b0));
    apply_stimulus(1'b1, 8'd9, 1'b0, 1'b1);
    check_output("basic");
    apply_stimulus(1'b0, 8'd0, 1'b0, 1'b1);
    check("basic_one_cycle", 32'(bus.sum_valid_o), 32'd0);
    check("basic_idle_busy", 32'(bus.busy_o), 32'd0);

    // Back-to-back groups with backpressure
    apply_stimulus(1'b1, 8'd1, 1'b0, 1'b0);
    apply_stimulus(1'b1, 8'd2, 1'b0, 1'b0);
    apply_stimulus(1'b1, 8'd3, 1'b0, 1'b0);
    sb.push_back(mk(10, 1'b0));
    apply_stimulus(1'b1, 8'd4, 1'b0, 1'b0);
    check_output("bp_first");
    apply_stimulus(1'b1, 8'd10, 1'b0, 1'b0);
    apply_stimulus(1'b1, 8'd20, 1'b0, 1'b0);
    apply_stimulus(1'b1, 8'd30, 1'b0, 1'b0);
    check("bp_hold_sum", 32'(bus.sum_o), 32'd10);
    check("bp_no_drop_yet", 32'(bus.drop_o), 32'd0);
    apply_stimulus(1'b1, 8'd40, 1'b0, 1'b0);
    check("bp_drop", 32'(bus.drop_o), 32'd1);
    check("bp_drop_sum", 32'(bus.sum_o), 32'd10);
    apply_stimulus(1'b0, 8'd0, 1'b0, 1'b0);
    check("bp_drop_once", 32'(bus.drop_o), 32'd0);
    check("bp_still_valid", 32'(bus.sum_valid_o), 32'd1);
    check("bp_still_sum", 32'(bus.sum_o), 32'd10);
    sb.push_back(mk(100, 1'b0));
    apply_stimulus(1'b1, 8'd40, 1'b0, 1'b1);
    check_output("bp_second");
    check("bp_second_drop", 32'(bus.drop_o), 32'd0);
    apply_stimulus(1'b0, 8'd0, 1'b0, 1'b1);
    check("bp_drained", 32'(bus.sum_valid_o), 32'd0);

    // Saturation: 225*4 exceeds 511
    apply_stimulus(1'b1, 8'd225, 1'b0, 1'b1);
    apply_stimulus(1'b1, 8'd225, 1'b0, 1'b1);
    apply_stimulus(1'b1, 8'd225, 1'b0, 1'b1);
    sb.push_back(mk(511, 1'b1));
    apply_stimulus(1'b1, 8'd225, 1'b0, 1'b1);
    check_output("sat");
    apply_stimulus(1'b1, 8'd1, 1'b0, 1'b1);
    apply_stimulus(1'b1, 8'd1, 1'b0, 1'b1);
    apply_stimulus(1'b1, 8'd1, 1'b0, 1'b1);
    sb.push_back(mk(4, 1'b0));
    apply_stimulus(1'b1, 8'd1, 1'b0, 1'b1);
    check_output("sat_follow");
    apply_stimulus(1'b0, 8'd0, 1'b0, 1'b1);

    // clear_i mid-group, with a simultaneous product
    apply_stimulus(1'b1, 8'd50, 1'b0, 1'b1);
    apply_stimulus(1'b1, 8'd60, 1'b0, 1'b1);
    apply_stimulus(1'b1, 8'd70, 1'b1, 1'b1);
    check("clr_drop", 32'(bus.drop_o), 32'd0);
    check("clr_busy", 32'(bus.busy_o), 32'd0);
    apply_stimulus(1'b1, 8'd2, 1'b0, 1'b1);
    apply_stimulus(1'b1, 8'd2, 1'b0, 1'b1);
    apply_stimulus(1'b1, 8'd2, 1'b0, 1'b1);
    sb.push_back(mk(8, 1'b0));
    apply_stimulus(1'b1, 8'd2, 1'b0, 1'b1);
    check_output("clr");
    check("clr_drop_end", 32'(bus.drop_o), 32'd0);
    apply_stimulus(1'b0, 8'd0, 1'b0, 1'b1);

    // Simultaneous transfer of 24 and load of 16
    apply_stimulus(1'b1, 8'd3, 1'b0, 1'b0);
    apply_stimulus(1'b1, 8'd5, 1'b0, 1'b0);
    apply_stimulus(1'b1, 8'd7, 1'b0, 1'b0);
    sb.push_back(mk(24, 1'b0));
    apply_stimulus(1'b1, 8'd9, 1'b0, 1'b0);
    check_output("xfer_first");
    apply_stimulus(1'b1, 8'd4, 1'b0, 1'b0);
    apply_stimulus(1'b1, 8'd4, 1'b0, 1'b0);
    apply_stimulus(1'b1, 8'd4, 1'b0, 1'b0);
    check("xfer_hold", 32'(bus.sum_o), 32'd24);
    sb.push_back(mk(16, 1'b0));
    apply_stimulus(1'b1, 8'd4, 1'b0, 1'b1);
    check_output("xfer_second");
    check("xfer_drop", 32'(bus.drop_o), 32'd0);
    apply_stimulus(1'b0, 8'd0, 1'b0, 1'b1);

    // Reset between edges with a sum held and a group in progress
    apply_stimulus(1'b1, 8'd1, 1'b0, 1'b0);
    apply_stimulus(1'b1, 8'd2, 1'b0, 1'b0);
    apply_stimulus(1'b1, 8'd3, 1'b0, 1'b0);
    sb.push_back(mk(10, 1'b0));
    apply_stimulus(1'b1, 8'd4, 1'b0, 1'b0);
    check_output("rst_held");
    apply_stimulus(1'b1, 8'd5, 1'b0, 1'b0);
    apply_stimulus(1'b1, 8'd6, 1'b0, 1'b0);
    bus.done_i = 1'b0;
    #2;
    rst_in = 1'b0;
    #1;
    check("arst_valid", 32'(bus.sum_valid_o), 32'd0);
    check("arst_sum", 32'(bus.sum_o), 32'd0);
    check("arst_busy", 32'(bus.busy_o), 32'd0);
    check("arst_ovf", 32'(bus.ovf_o), 32'd0);
    check("arst_drop", 32'(bus.drop_o), 32'd0);
    @(posedge clk_in);
    #1;
    rst_in = 1'b1;
    apply_stimulus(1'b1, 8'd1, 1'b0, 1'b1);
    apply_stimulus(1'b1, 8'd2, 1'b0, 1'b1);
    apply_stimulus(1'b1, 8'd3, 1'b0, 1'b1);
    check("post_rst_early", 32'(bus.sum_valid_o), 32'd0);
    sb.push_back(mk(10, 1'b0));
    apply_stimulus(1'b1, 8'd4, 1'b0, 1'b1);
    check_output("post_rst");
    apply_stimulus(1'b0, 8'd0, 1'b0, 1'b1);
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mult_result_accumulator.md
# mult_result_accumulator

Downstream consumer of the 4x4 multiplier stage. It captures each product as the multiplier reports it through done/out_data, sums groups of NUM_TERMS consecutive products, and presents each group sum through a valid/ready output register. Accumulation of the next group continues while a completed sum waits for the sink. A product is lost only when that next group also completes before the held sum is taken.

## Interface
- PROD_W, 8: product width; matches multiplier out_data.
- NUM_TERMS, 4: products per group; legal range 2..16.
- ACC_W, 10: sum width; must be at least PROD_W.
- clk_in  input  1  sole clock, rising edge.
- rst_in  input  1  reset, asynchronous assert, active-low (0 = reset).
- done_i  input  1  product-valid pulse; driven by the multiplier done_o.
- prod_i  input  PROD_W  product; driven by the multiplier out_data; sampled only when done_i=1.
- clear_i  input  1  synchronous abort of the group in progress.
- sum_o  output  ACC_W  group sum; stable while sum_valid_o=1.
- ovf_o  output  1  saturation flag for the group presented on sum_o.
- sum_valid_o  output  1  sum_o/ovf_o valid.
- sum_ready_i  input  1  sink accepts sum_o.
- busy_o  output  1  group partially accumulated or sum held.
- drop_o  output  1  one-cycle pulse: product discarded.

## Operation
- Internal state:
  - acc (ACC_W): running sum.
  - cnt (0..NUM_TERMS-1): products in the current group.
  - acc_ovf: sticky saturation flag for the current group.
- Output register: sum_o, ovf_o, sum_valid_o.
- Product arrival (done_i=1, clear_i=0):
  - Add in ACC_W+1 bits. On carry out, acc saturates to all-ones and acc_ovf is set. A saturated acc stays saturated for the rest of the group.
  - Not the last product (cnt < NUM_TERMS-1): acc takes the sum and cnt increments.
  - Last product (cnt = NUM_TERMS-1), with the output register free (sum_valid_o=0, or sum_valid_o=1 and sum_ready_i=1 this cycle):
    - sum_o takes the final sum and ovf_o takes the final flag.
    - sum_valid_o is 1.
    - acc, cnt and acc_ovf clear to 0.
  - Last product with the output register stalled (sum_valid_o=1, sum_ready_i=0):
    - The product is discarded and drop_o pulses.
    - acc, cnt and acc_ovf are unchanged. The group completes on the next product that arrives after the stall clears.
- Handshake:
  - A transfer occurs on a cycle with sum_valid_o=1 and sum_ready_i=1.
  - After a transfer with no new load in the same cycle, sum_valid_o clears.
  - A transfer and a new load in the same cycle keep sum_valid_o=1 with the new values.
  - Held values never change without a transfer.
- clear_i=1:
  - acc, cnt and acc_ovf clear to 0.
  - A simultaneous done_i product is ignored; it is not a drop and drop_o stays 0.
  - The output register and the handshake are unaffected.
- busy_o = (cnt != 0) or (acc != 0) or sum_valid_o.
- Reset drives every register to 0: sum_o=0, ovf_o=0, sum_valid_o=0, drop_o=0, busy_o=0, acc=0, cnt=0, acc_ovf=0.
- Reset mid-group or mid-hold loses all state; no sum is emitted for the interrupted group.

## Timing
- Latency: the final done_i sampled at edge N makes sum_valid_o=1 after edge N, i.e. in cycle N+1.
- Throughput: one product per cycle sustained; done_i may be high on consecutive cycles.
- No output depends combinationally on done_i, prod_i or sum_ready_i.
- drop_o is registered and asserts the cycle after the discarded product.
- rst_in assertion takes effect immediately, without a clock edge. Deassertion is synchronized externally; the block takes no action until the first edge after release.

## Test plan
- Basic group:
  - Stimulus: done_i pulses with prod_i = 3, 5, 7, 9; sum_ready_i=1.
  - Required: sum_o=24, ovf_o=0, sum_valid_o=1 for exactly one cycle, the cycle after the 9 is sampled.
- Back-to-back with backpressure:
  - Stimulus: products 1..4 on consecutive cycles, then products 10, 20, 30, 40 on consecutive cycles; sum_ready_i=0 throughout both groups.
  - Required: sum_o=10 is held; the 40 is dropped and drop_o pulses once; sum_o stays 10.
  - Then raise sum_ready_i and send product 40. Required: the transfer of 10, then sum_o=100 with sum_valid_o=1.
- Saturation (ACC_W=9):
  - Stimulus: four products of 225.
  - Required: sum_o=511, ovf_o=1.
  - Follow-up group 1, 1, 1, 1. Required: sum_o=4, ovf_o=0.
- clear_i mid-group:
  - Stimulus: products 50, 60; then clear_i together with done_i and product 70; then products 2, 2, 2, 2.
  - Required: sum_o=8, drop_o never asserts.
- Simultaneous transfer and load:
  - Stimulus: sum_o=24 held; the final product of the next group (sum 16) arrives in the same cycle as sum_ready_i=1.
  - Required: sum_valid_o stays 1, the next cycle shows sum_o=16, no drop.
- Reset mid-operation:
  - Stimulus: assert rst_in=0 between clock edges after two products, with a sum held.
  - Required: all outputs 0 immediately. After release, group 1, 2, 3, 4 gives sum_o=10.
